// File: rtl/asym_bram_pipe.sv
// ---------------------------------------------------------------------------
// asym_bram_pipe
//   Simple dual-port (one write, one read) block RAM whose read and write
//   ports may have different widths; either side may be the wider one.
//   Storage is organised as minW-bit lanes. A wide-side word is RATIO
//   consecutive lanes with lane 0 in the LSBs. The lanes are split over RATIO
//   banks (bank = low lane-address bits), so the wide side touches every bank
//   at one row and the narrow side touches a single bank.
//   Extras: per-lane write mask, optional output register, a one-cycle read
//   valid strobe, and a zeroing sweep of every lane after reset.
//
// Ports
//   clk           clock
//   rst           asynchronous reset, active high
//   ready         memory accepts reads and writes
//   w_valid       write request
//   w_addr        write address in write-width units
//   w_data        write data
//   w_mask        per-lane write enable (one bit when the write side is narrow)
//   r_valid       read request
//   r_addr        read address in read-width units
//   r_data        read data, holds its value between reads
//   r_data_valid  pulses for one cycle when r_data carries a new read
// ---------------------------------------------------------------------------
module asym_bram_pipe #(
  parameter int READ_WIDTH       = 80,
  parameter int READ_ADDR_WIDTH  = 9,
  parameter int WRITE_WIDTH      = 40,
  parameter int WRITE_ADDR_WIDTH = 10,
  parameter int OUT_REG          = 0,
  parameter int CLEAR_ON_RESET   = 1,
  localparam int MIN_W  = (READ_WIDTH < WRITE_WIDTH) ? READ_WIDTH : WRITE_WIDTH,
  localparam int MASK_W = WRITE_WIDTH / MIN_W
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        ready,
  input  logic                        w_valid,
  input  logic [WRITE_ADDR_WIDTH-1:0] w_addr,
  input  logic [WRITE_WIDTH-1:0]      w_data,
  input  logic [MASK_W-1:0]           w_mask,
  input  logic                        r_valid,
  input  logic [READ_ADDR_WIDTH-1:0]  r_addr,
  output logic [READ_WIDTH-1:0]       r_data,
  output logic                        r_data_valid
);

  localparam int MAX_W  = (READ_WIDTH > WRITE_WIDTH) ? READ_WIDTH : WRITE_WIDTH;
  localparam int RATIO  = MAX_W / MIN_W;
  localparam int RB     = $clog2(RATIO);
  localparam int LAW    = (READ_ADDR_WIDTH > WRITE_ADDR_WIDTH) ? READ_ADDR_WIDTH
                                                               : WRITE_ADDR_WIDTH;
  localparam int DEPTH  = 2 ** LAW;
  localparam int ROWS   = DEPTH / RATIO;
  localparam int ROW_AW = LAW - RB;
  localparam int SEL_W  = (RB > 0) ? RB : 1;
  localparam bit W_WIDE = (WRITE_WIDTH > READ_WIDTH);
  localparam bit R_WIDE = (READ_WIDTH > WRITE_WIDTH);

  // Elaboration-time sanity checks on the geometry.
  if ((MAX_W % MIN_W) != 0 || (RATIO & (RATIO - 1)) != 0) begin : g_bad_ratio
    $error("asym_bram_pipe: width ratio must be a power of two");
  end
  if (READ_WIDTH * (2 ** READ_ADDR_WIDTH) != WRITE_WIDTH * (2 ** WRITE_ADDR_WIDTH))
  begin : g_bad_size
    $error("asym_bram_pipe: read and write ports must cover the same number of bits");
  end

  // -------------------------------------------------------------------------
  // Control FSM: CLEAR sweeps one lane per edge, INIT is the single-edge wait
  // used when no sweep is wanted, READY accepts traffic.
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_INIT  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_INIT;

  state_t           state, state_next;
  logic [LAW-1:0]   clr_cnt, clr_cnt_next;
  logic             clr_en;
  logic             wr_en, rd_en;
  logic [ROW_AW-1:0] clr_row;

  // NOTE: every sequential block uses non-blocking assignments so all
  // registers sample pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RESET_STATE;
      clr_cnt <= '0;
    end else begin
      state   <= state_next;
      clr_cnt <= clr_cnt_next;
    end
  end

  // NOTE: each signal written here gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_next   = state;
    clr_cnt_next = clr_cnt;
    clr_en       = 1'b0;
    ready        = 1'b0;
    unique case (state)
      ST_CLEAR: begin
        clr_en       = 1'b1;
        clr_cnt_next = clr_cnt + 1'b1;
        // The edge that zeroes the last lane is the one that opens the memory.
        if (&clr_cnt) state_next = ST_READY;
      end
      ST_INIT:  state_next = ST_READY;
      ST_READY: ready      = 1'b1;
      default:  state_next = RESET_STATE;
    endcase
  end

  assign wr_en   = ready & w_valid;
  assign rd_en   = ready & r_valid;
  assign clr_row = ROW_AW'(clr_cnt >> RB);

  // -------------------------------------------------------------------------
  // Lane banks
  // -------------------------------------------------------------------------
  logic [RATIO*MIN_W-1:0] bank_q;

  for (genvar b = 0; b < RATIO; b++) begin : g_bank
    logic [MIN_W-1:0]  mem [ROWS];
    logic              we, re;
    logic [ROW_AW-1:0] wrow, rrow;
    logic [MIN_W-1:0]  wdata, q;
    logic [ROW_AW-1:0] w_row_req;
    logic [MIN_W-1:0]  w_lane_data;
    logic              w_lane_en, r_hit, clr_hit;

    if (W_WIDE) begin : g_wwide
      // Wide write: every bank takes its own slice at row w_addr.
      assign w_row_req   = ROW_AW'(w_addr);
      assign w_lane_data = w_data[b*MIN_W +: MIN_W];
      assign w_lane_en   = w_mask[b];
    end else begin : g_wnarrow
      // Narrow write: low address bits pick the bank, the rest pick the row.
      assign w_row_req   = ROW_AW'(w_addr >> RB);
      assign w_lane_data = MIN_W'(w_data);
      assign w_lane_en   = w_mask[0] && ((32'(w_addr) & (RATIO - 1)) == b);
    end

    if (R_WIDE) begin : g_rwide
      assign rrow  = ROW_AW'(r_addr);
      assign r_hit = 1'b1;
    end else begin : g_rnarrow
      assign rrow  = ROW_AW'(r_addr >> RB);
      assign r_hit = ((32'(r_addr) & (RATIO - 1)) == b);
    end

    assign clr_hit = ((32'(clr_cnt) & (RATIO - 1)) == b);
    assign re      = rd_en & r_hit;

    // The sweep owns the write port while it runs; user writes are gated by
    // ready and so cannot collide with it.
    always_comb begin
      we    = 1'b0;
      wrow  = w_row_req;
      wdata = w_lane_data;
      if (clr_en) begin
        we    = clr_hit;
        wrow  = clr_row;
        wdata = '0;
      end else begin
        we    = wr_en & w_lane_en;
      end
    end

    // NOTE: the storage array has no reset; clearing it is the job of the
    // post-reset sweep, which keeps the array mappable onto block RAM.
    always_ff @(posedge clk) begin
      if (we) mem[wrow] <= wdata;
    end

    // Reading the pre-edge array contents gives read-first behaviour on a
    // same-cycle collision.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)     q <= '0;
      else if (re) q <= mem[rrow];
    end

    assign bank_q[b*MIN_W +: MIN_W] = q;
  end

  // -------------------------------------------------------------------------
  // Read data assembly and output pipeline
  // -------------------------------------------------------------------------
  logic [READ_WIDTH-1:0] s1_data;
  logic                  s1_valid;

  if (R_WIDE) begin : g_rd_wide
    assign s1_data = bank_q;
  end else begin : g_rd_narrow
    // Remember which bank the last read targeted so r_data holds steady
    // between reads.
    logic [SEL_W-1:0] rd_sel;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)        rd_sel <= '0;
      else if (rd_en) rd_sel <= SEL_W'(32'(r_addr) & (RATIO - 1));
    end
    assign s1_data = bank_q[rd_sel*MIN_W +: MIN_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) s1_valid <= 1'b0;
    else     s1_valid <= rd_en;
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [READ_WIDTH-1:0] o_data;
    logic                  o_valid;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        o_data  <= '0;
        o_valid <= 1'b0;
      end else begin
        o_valid <= s1_valid;
        if (s1_valid) o_data <= s1_data;
      end
    end
    assign r_data       = o_data;
    assign r_data_valid = o_valid;
  end else begin : g_out_direct
    assign r_data       = s1_data;
    assign r_data_valid = s1_valid;
  end

endmodule

// File: tb/tb_asym_bram_pipe.sv
// ---------------------------------------------------------------------------
// tb_asym_bram_pipe
//   Instance a: default geometry (80-bit read, 40-bit write, OUT_REG=0).
//   Instance b: 40-bit read, 80-bit write, OUT_REG=1.
//   Each instance is compared against a flat array of 40-bit lanes.
// ---------------------------------------------------------------------------
module tb_asym_bram_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance a signals
  logic        rst_a, ready_a, w_valid_a, r_valid_a, r_data_valid_a;
  logic [9:0]  w_addr_a;
  logic [39:0] w_data_a;
  logic [0:0]  w_mask_a;
  logic [8:0]  r_addr_a;
  logic [79:0] r_data_a;

  // Instance b signals
  logic        rst_b, ready_b, w_valid_b, r_valid_b, r_data_valid_b;
  logic [8:0]  w_addr_b;
  logic [79:0] w_data_b;
  logic [1:0]  w_mask_b;
  logic [9:0]  r_addr_b;
  logic [39:0] r_data_b;

  asym_bram_pipe dut_a (
    .clk(clk), .rst(rst_a), .ready(ready_a),
    .w_valid(w_valid_a), .w_addr(w_addr_a), .w_data(w_data_a), .w_mask(w_mask_a),
    .r_valid(r_valid_a), .r_addr(r_addr_a), .r_data(r_data_a),
    .r_data_valid(r_data_valid_a)
  );

  asym_bram_pipe #(
    .READ_WIDTH(40), .READ_ADDR_WIDTH(10), .WRITE_WIDTH(80), .WRITE_ADDR_WIDTH(9),
    .OUT_REG(1), .CLEAR_ON_RESET(1)
  ) dut_b (
    .clk(clk), .rst(rst_b), .ready(ready_b),
    .w_valid(w_valid_b), .w_addr(w_addr_b), .w_data(w_data_b), .w_mask(w_mask_b),
    .r_valid(r_valid_b), .r_addr(r_addr_b), .r_data(r_data_b),
    .r_data_valid(r_data_valid_b)
  );

  // Reference state: memory as plain lanes, plus what each output should show.
  logic [39:0] lanes_a [1024];
  logic [39:0] lanes_b [1024];
  bit          a_up, b_up, b_pend;
  logic [79:0] a_last;
  logic [39:0] b_last, b_pend_data;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock of instance a. Inputs applied now, checked #1 after the edge.
  task automatic a_cycle(input logic wv, input logic [9:0] wa, input logic [39:0] wd,
                         input logic wm, input logic rv, input logic [8:0] ra);
    logic [79:0] exp;
    bit          rd;
    w_valid_a = wv; w_addr_a = wa; w_data_a = wd; w_mask_a = wm;
    r_valid_a = rv; r_addr_a = ra;
    rd  = rv && a_up;
    exp = {lanes_a[{ra, 1'b1}], lanes_a[{ra, 1'b0}]};  // old contents: read-first
    @(posedge clk);
    if (wv && wm && a_up) lanes_a[wa] = wd;
    if (rd) a_last = exp;
    #1;
    check("a_valid", 80'(r_data_valid_a), 80'(rd));
    check("a_data", r_data_a, a_last);
  endtask

  // One clock of instance b (read result appears one edge after issue).
  task automatic b_cycle(input logic wv, input logic [8:0] wa, input logic [79:0] wd,
                         input logic [1:0] wm, input logic rv, input logic [9:0] ra);
    logic [39:0] exp;
    bit          rd, exp_valid;
    w_valid_b = wv; w_addr_b = wa; w_data_b = wd; w_mask_b = wm;
    r_valid_b = rv; r_addr_b = ra;
    rd  = rv && b_up;
    exp = lanes_b[ra];
    @(posedge clk);
    if (wv && b_up) begin
      if (wm[0]) lanes_b[{wa, 1'b0}] = wd[39:0];
      if (wm[1]) lanes_b[{wa, 1'b1}] = wd[79:40];
    end
    exp_valid = b_pend;
    if (b_pend) b_last = b_pend_data;
    b_pend      = rd;
    b_pend_data = exp;
    #1;
    check("b_valid", 80'(r_data_valid_b), 80'(exp_valid));
    check("b_data", 80'(r_data_b), 80'(b_last));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int ea, eb, edges;

    rst_a = 1'b1; rst_b = 1'b1;
    w_valid_a = 0; w_addr_a = '0; w_data_a = '0; w_mask_a = '0; r_valid_a = 0; r_addr_a = '0;
    w_valid_b = 0; w_addr_b = '0; w_data_b = '0; w_mask_b = '0; r_valid_b = 0; r_addr_b = '0;
    a_up = 0; b_up = 0; b_pend = 0; a_last = '0; b_last = '0; b_pend_data = '0;
    for (int i = 0; i < 1024; i++) begin lanes_a[i] = '0; lanes_b[i] = '0; end

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready_a", 80'(ready_a), 80'(0));
    check("rst_rdata_a", r_data_a, 80'(0));
    check("rst_rvalid_a", 80'(r_data_valid_a), 80'(0));
    check("rst_ready_b", 80'(ready_b), 80'(0));
    check("rst_rdata_b", 80'(r_data_b), 80'(0));

    // T1: sweep length, both instances
    rst_a = 1'b0; rst_b = 1'b0;
    ea = 0; eb = 0; edges = 0;
    while ((ea == 0 || eb == 0) && edges < 3000) begin
      @(posedge clk); #1; edges++;
      if (ea == 0 && ready_a === 1'b1) ea = edges;
      if (eb == 0 && ready_b === 1'b1) eb = edges;
    end
    check("sweep_edges_a", 80'(ea), 80'(1024));
    check("sweep_edges_b", 80'(eb), 80'(1024));
    a_up = 1; b_up = 1;

    a_cycle(0, '0, '0, 0, 1, 9'd137);
    check("t1_zero", r_data_a, 80'h0);
    check("t1_valid", 80'(r_data_valid_a), 80'(1));
    a_cycle(0, '0, '0, 0, 0, '0);
    a_cycle(0, '0, '0, 0, 1, 9'd511);

    // T2: narrow writes assemble into a wide read; masked write ignored
    a_cycle(1, 10'd6, 40'h11_1111_1111, 1, 0, '0);
    a_cycle(1, 10'd7, 40'h22_2222_2222, 1, 0, '0);
    a_cycle(0, '0, '0, 0, 1, 9'd3);
    check("t2_word", r_data_a, 80'h22_2222_2222_11_1111_1111);
    a_cycle(1, 10'd6, 40'hDE_AD00_BEEF, 0, 0, '0);
    a_cycle(0, '0, '0, 0, 1, 9'd3);
    check("t2_masked", r_data_a, 80'h22_2222_2222_11_1111_1111);

    // T4: same-edge collision returns old data, later read sees new
    a_cycle(1, 10'd6, 40'h33_3333_3333, 1, 0, '0);
    a_cycle(1, 10'd6, 40'h44_4444_4444, 1, 1, 9'd3);
    check("t4_old", r_data_a[39:0], 80'h33_3333_3333);
    a_cycle(0, '0, '0, 0, 1, 9'd3);
    check("t4_new", r_data_a[39:0], 80'h44_4444_4444);

    // Random traffic on a small window to provoke overlaps
    for (int i = 0; i < 150; i++) begin
      a_cycle(1'($urandom_range(0, 1)), 10'($urandom_range(0, 31)),
              40'({$urandom(), $urandom()}), 1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 1)), 9'($urandom_range(0, 15)));
    end
    a_cycle(0, '0, '0, 0, 0, '0);

    // T5: reset mid-sweep, junk writes during the sweep have no effect
    #1 rst_a = 1'b1; a_up = 0;
    #1;
    check("t5_rst_ready", 80'(ready_a), 80'(0));
    check("t5_rst_data", r_data_a, 80'(0));
    a_last = '0;
    @(posedge clk); #1 rst_a = 1'b0;
    for (int i = 0; i < 500; i++) begin
      w_valid_a = 1; w_addr_a = 10'($urandom_range(0, 7)); w_data_a = 40'($urandom());
      w_mask_a = 1; r_valid_a = 1; r_addr_a = 9'($urandom_range(0, 3));
      @(posedge clk); #1;
      if (i % 50 == 0) begin
        check("t5_sweep_ready", 80'(ready_a), 80'(0));
        check("t5_sweep_valid", 80'(r_data_valid_a), 80'(0));
      end
    end
    rst_a = 1'b1;
    @(posedge clk); #1 rst_a = 1'b0;
    edges = 0;
    while (ready_a !== 1'b1 && edges < 3000) begin
      w_valid_a = 1; w_addr_a = 10'($urandom_range(0, 7)); w_data_a = 40'($urandom());
      w_mask_a = 1; r_valid_a = 1; r_addr_a = 9'($urandom_range(0, 3));
      @(posedge clk); #1; edges++;
      if (edges % 100 == 0) check("t5_resweep_valid", 80'(r_data_valid_a), 80'(0));
    end
    check("t5_resweep_edges", 80'(edges), 80'(1024));
    for (int i = 0; i < 1024; i++) lanes_a[i] = '0;
    a_up = 1;
    for (int i = 0; i < 4; i++) a_cycle(0, '0, '0, 0, 1, 9'(i));
    check("t5_zero", r_data_a, 80'h0);

    // T3: wide masked writes, narrow reads (instance b)
    b_cycle(1, 9'd2, {40'hBB_BBBB_BBBB, 40'hAA_AAAA_AAAA}, 2'b11, 0, '0);
    b_cycle(1, 9'd2, {40'hCC_CCCC_CCCC, 40'hDD_DDDD_DDDD}, 2'b01, 0, '0);
    b_cycle(0, '0, '0, '0, 1, 10'd4);
    b_cycle(0, '0, '0, '0, 1, 10'd5);
    check("t3_lane4", 80'(r_data_b), 80'h00_0000_0000_DD_DDDD_DDDD);
    b_cycle(0, '0, '0, '0, 0, '0);
    check("t3_lane5", 80'(r_data_b), 80'h00_0000_0000_BB_BBBB_BBBB);

    // T6: back-to-back reads through the output register
    for (int i = 0; i < 4; i++)
      b_cycle(1, 9'(i), {$urandom(), $urandom(), 16'($urandom())}, 2'b11, 0, '0);
    for (int i = 0; i < 8; i++) b_cycle(0, '0, '0, '0, 1, 10'(i));
    b_cycle(0, '0, '0, '0, 0, '0);
    b_cycle(0, '0, '0, '0, 0, '0);

    for (int i = 0; i < 150; i++) begin
      b_cycle(1'($urandom_range(0, 1)), 9'($urandom_range(0, 15)),
              {$urandom(), $urandom(), 16'($urandom())}, 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 10'($urandom_range(0, 31)));
    end

    // Reset with reads in flight: nothing more comes out
    b_cycle(0, '0, '0, '0, 1, 10'd0);
    b_cycle(0, '0, '0, '0, 1, 10'd1);
    rst_b = 1'b1; b_up = 0; b_pend = 0; b_last = '0;
    #1;
    check("t6_rst_valid", 80'(r_data_valid_b), 80'(0));
    check("t6_rst_data", 80'(r_data_b), 80'(0));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("t6_hold_valid", 80'(r_data_valid_b), 80'(0));
    end
    rst_b = 1'b0; r_valid_b = 0;
    edges = 0;
    while (ready_b !== 1'b1 && edges < 3000) begin
      @(posedge clk); #1; edges++;
      if (r_data_valid_b !== 1'b0) check("t6_sweep_valid", 80'(r_data_valid_b), 80'(0));
    end
    check("t6_resweep_edges", 80'(edges), 80'(1024));
    for (int i = 0; i < 1024; i++) lanes_b[i] = '0;
    b_up = 1;
    for (int i = 0; i < 4; i++) b_cycle(0, '0, '0, '0, 1, 10'(i));
    b_cycle(0, '0, '0, '0, 0, '0);
    check("t6_zero", 80'(r_data_b), 80'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
